divider_seq_nr: RTL and testbench

- Parametrised, multi-cycle, non-restoring unsigned integer divider. Produces one quotient bit per clock.
- Replaces the fully unrolled combinational divider in area-sensitive datapaths.
- Adds valid/ready handshakes on both sides, output backpressure, and divide-by-zero detection.
- Quotient and remainder widths follow the parameters.

---
 rtl/divider_seq_nr.sv | 112 +++++++++++
 tb/tb_divider_seq_nr.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_nr.sv
// Sequential non-restoring unsigned divider: one quotient bit per clock,
// valid/ready handshakes on both sides and divide-by-zero flagging.
module divider_seq_nr #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int N  = DIVIDEND_W;
    localparam int M  = DIVISOR_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic signed [M:0]     p_q;
    logic [N-1:0]          q_q;
    logic [M-1:0]          b_q;
    logic                  zero_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [N-1:0]          quot_q;
    logic [M-1:0]          rem_q;
    logic                  dbz_q;

    logic signed [M:0]     b_ext;
    logic signed [M:0]     p_sh;
    logic signed [M:0]     p_d;
    logic [N-1:0]          q_d;
    logic signed [M:0]     p_fix;

    // P only needs M+1 bits: the true value after each step lies in [-B, B-1],
    // so the MSB lost by the shift is recovered by wrap-around arithmetic.
    always_comb begin
        b_ext = signed'({1'b0, b_q});
        p_sh  = signed'({p_q[M-1:0], q_q[N-1]});
        p_d   = p_q[M] ? (p_sh + b_ext) : (p_sh - b_ext);
        q_d   = {q_q[N-2:0], ~p_d[M]};
        p_fix = p_q[M] ? (p_q + b_ext) : p_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            b_q         <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        b_q        <= divisor;
                        q_q        <= dividend;
                        p_q        <= '0;
                        cnt_q      <= CW'(N - 1);
                        zero_q     <= (divisor == '0);
                        // Divide-by-zero skips the iterations and only uses the load step.
                        state_q    <= (divisor == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q      <= zero_q ? '1 : q_q;
                    rem_q       <= zero_q ? '0 : p_fix[M-1:0];
                    dbz_q       <= zero_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_seq_nr.sv
// Scoreboard bench for divider_seq_nr: 8/4 instance (directed, backpressure,
// reset, back-to-back, full sweep) and a 16/8 instance (directed).
module tb_divider_seq_nr;
    localparam int N  = 8;
    localparam int M  = 4;
    localparam int NW = 16;
    localparam int MW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, out_valid, div_by_zero;
    logic          out_ready = 1'b1;
    logic [N-1:0]  dividend, quotient;
    logic [M-1:0]  divisor, remainder;

    logic          w_in_valid, w_in_ready, w_out_valid, w_dbz;
    logic          w_out_ready = 1'b1;
    logic [NW-1:0] w_dividend, w_quotient;
    logic [MW-1:0] w_divisor, w_remainder;

    divider_seq_nr #(.DIVIDEND_W(N), .DIVISOR_W(M)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    divider_seq_nr #(.DIVIDEND_W(NW), .DIVISOR_W(MW)) u_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .dividend(w_dividend), .divisor(w_divisor),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .quotient(w_quotient), .remainder(w_remainder), .div_by_zero(w_dbz)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t sbw[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   hs_cyc = 0;
    int   or_mode = 1;
    bit   chain = 1'b0;
    logic ov_prev = 1'b0;
    logic wov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // out_ready driver: 0 = held low, 1 = held high, otherwise random (~75% high)
    initial forever begin
        @(posedge clk);
        #2;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_prev && sb.size() != 0)
                chk("latency", 64'(cyc - sb[0].acc), sb[0].z ? 64'd1 : 64'(N + 1));
            if (out_valid && out_ready) begin
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("quotient", quotient, sb[0].q);
                    chk("remainder", remainder, sb[0].r);
                    chk("div_by_zero", div_by_zero, sb[0].z);
                    void'(sb.pop_front());
                end
                hs_cyc <= cyc + 1;
            end
        end
        ov_prev <= out_valid;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (w_out_valid && !wov_prev && sbw.size() != 0)
                chk("w_latency", 64'(cyc - sbw[0].acc), sbw[0].z ? 64'd1 : 64'(NW + 1));
            if (w_out_valid && w_out_ready) begin
                chk("w_sb_nonempty", sbw.size() != 0, 1);
                if (sbw.size() != 0) begin
                    chk("w_quotient", w_quotient, sbw[0].q);
                    chk("w_remainder", w_remainder, sbw[0].r);
                    chk("w_div_by_zero", w_dbz, sbw[0].z);
                    void'(sbw.pop_front());
                end
            end
        end
        wov_prev <= w_out_valid;
    end

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic send(input int a, input int b, input int eq, input int er,
                        input bit ez, input bit keep);
        exp_t e;
        int t = 0;
        in_valid = 1'b1;
        dividend = N'(a);
        divisor  = M'(b);
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            e.q = eq; e.r = er; e.z = ez; e.acc = cyc + 1;
            sb.push_back(e);
            if (keep && chain) chk("b2b_gap", 64'(e.acc - hs_cyc), 1);
            @(posedge clk);
            #1;
            if (!keep) in_valid = 1'b0;
            dividend = N'($urandom);
            divisor  = M'($urandom);
        end
    endtask

    task automatic sendw(input int a, input int b, input int eq, input int er, input bit ez);
        exp_t e;
        int t = 0;
        w_in_valid = 1'b1;
        w_dividend = NW'(a);
        w_divisor  = MW'(b);
        @(negedge clk);
        while (!w_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("w_accept", w_in_ready, 1);
        if (w_in_ready) begin
            e.q = eq; e.r = er; e.z = ez; e.acc = cyc + 1;
            sbw.push_back(e);
            @(posedge clk);
        end
        #1;
        w_in_valid = 1'b0;
        w_dividend = NW'($urandom);
        w_divisor  = MW'($urandom);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || sbw.size() != 0 || !in_ready || !w_in_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 64'(sb.size() + sbw.size()), 0);
        @(posedge clk);
        #1;
    endtask

    int dir_a[8] = '{200, 0, 13, 255, 3, 250, 128, 99};
    int dir_b[8] = '{7,   5, 13, 1,   10, 0,  15,  4};
    int dir_q[8] = '{28,  0, 1,  255, 0,  255, 8,  24};
    int dir_r[8] = '{4,   0, 0,  0,   3,  0,   8,  3};

    initial begin
        int t;
        rst_n = 1'b0;
        in_valid = 1'b0; dividend = '0; divisor = '0;
        w_in_valid = 1'b0; w_dividend = '0; w_divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(200, 7, 28, 4, 1'b0, 1'b0);
        t = 0;
        do begin
            @(negedge clk);
            chk("busy_in_ready", in_ready, 0);
            t++;
        end while (!out_valid && t < 20);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            send(dir_a[i], dir_b[i], dir_q[i], dir_r[i], dir_b[i] == 0, 1'b0);
            wait_idle();
        end

        or_mode = 0;
        send(255, 15, 17, 0, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("bp_done", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            dividend = 8'd3;
            divisor  = 4'd1;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_quotient", quotient, 17);
            chk("bp_remainder", remainder, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        or_mode = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_rel_out_valid", out_valid, 0);
        chk("bp_rel_in_ready", in_ready, 1);
        wait_idle();

        send(100, 3, 33, 1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_quotient", quotient, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(5, 9, 0, 5, 1'b0, 1'b0);
        wait_idle();

        chain = 1'b0;
        send(17, 5, 3, 2, 1'b0, 1'b1);
        chain = 1'b1;
        send(200, 9, 22, 2, 1'b0, 1'b1);
        send(77, 0, 255, 0, 1'b1, 1'b1);
        send(64, 8, 8, 0, 1'b0, 1'b1);
        send(11, 12, 0, 11, 1'b0, 1'b0);
        chain = 1'b0;
        wait_idle();

        or_mode = 2;
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 16; b++)
                send(a, b, (b != 0) ? a / b : 255, (b != 0) ? a % b : 0, b == 0, 1'b0);
        or_mode = 1;
        wait_idle();

        sendw(50000, 255, 196, 20, 1'b0);
        wait_idle();
        sendw(65535, 1, 65535, 0, 1'b0);
        wait_idle();
        sendw(1000, 0, 65535, 0, 1'b1);
        wait_idle();
        sendw(12345, 100, 123, 45, 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
